// File: rtl/store_buffer_pkg.sv
// Store buffer shared constants and entry type.
// Defaults match a 1 KiB word-addressed data memory.
package store_buffer_pkg;

  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 32;
  localparam int SB_DEPTH   = 4;

  typedef struct packed {
    logic [ADDR_WIDTH-3:0] waddr;
    logic [DATA_WIDTH-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-first match of a load word address against live buffer entries.
// Used by store_buffer only when STORE_FWD_EN is defined.
module sb_fwd_match #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0][AW-1:0]   waddrs,
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [AW-1:0]              key,
  output logic                       hit,
  output logic [$clog2(DEPTH)-1:0]   idx
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] p;

  // Walk oldest to youngest so the last hit wins.
  always_comb begin
    hit = 1'b0;
    idx = head;
    p   = head;
    for (int k = 0; k < DEPTH; k++) begin
      p = head + PW'(k);
      if ((CW'(k) < count) && (waddrs[p] == key)) begin
        hit = 1'b1;
        idx = p;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer in front of a single-port data memory.
// Define STORE_FWD_EN to forward buffered data to matching loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int addressWidth = ADDR_WIDTH,
  parameter int dataWidth    = DATA_WIDTH,
  parameter int DEPTH        = SB_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_we,
  input  logic [addressWidth-1:0] cpu_addr,
  input  logic [dataWidth-1:0]    cpu_wd,
  output logic                    cpu_stall,
  input  logic                    ld_req,
  input  logic [addressWidth-1:0] ld_addr,
  output logic [dataWidth-1:0]    ld_data,
  output logic                    ld_stall,
  output logic                    mem_WE,
  output logic [addressWidth-1:0] mem_Address,
  output logic [dataWidth-1:0]    mem_WD,
  input  logic [dataWidth-1:0]    mem_RD,
  output logic                    empty
);

  localparam int AW = addressWidth - 2;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][AW-1:0]        waddr_q;
  logic [DEPTH-1:0][dataWidth-1:0] data_q;
  logic [PW-1:0]                   head;
  logic [PW-1:0]                   tail;
  logic [CW-1:0]                   count;
  logic [AW-1:0]                   ld_waddr;
  logic                            match;
  logic                            ld_port;
  logic                            pop;
  logic                            accept;
  logic                            unused_bits;

  assign ld_waddr    = ld_addr[addressWidth-1:2];
  assign unused_bits = ^{cpu_addr[1:0], ld_addr[1:0]};

`ifdef STORE_FWD_EN
  logic [PW-1:0] match_idx;

  sb_fwd_match #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_match (
    .waddrs (waddr_q),
    .head   (head),
    .count  (count),
    .key    (ld_waddr),
    .hit    (match),
    .idx    (match_idx)
  );

  assign ld_data  = match ? data_q[match_idx] : mem_RD;
  assign ld_stall = 1'b0;
`else
  always_comb begin
    match = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) &&
          (waddr_q[head + PW'(k)] == ld_waddr))
        match = 1'b1;
    end
  end

  assign ld_data  = mem_RD;
  assign ld_stall = ld_req && match;
`endif

  // A load only takes the port when the buffer cannot answer it.
  assign ld_port   = ld_req && !match;
  assign pop       = !ld_port && (count != '0);
  assign accept    = cpu_we && ((count != CW'(DEPTH)) || pop);
  assign cpu_stall = cpu_we && !accept;
  assign empty     = (count == '0);

  assign mem_WE      = pop;
  assign mem_Address = ld_port ? {ld_waddr, 2'b00}
                               : {waddr_q[head], 2'b00};
  assign mem_WD      = data_q[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)    head <= head + PW'(1);
      if (accept) tail <= tail + PW'(1);
      unique case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is not reset; count alone decides what is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      waddr_q[tail] <= cpu_addr[addressWidth-1:2];
      data_q[tail]  <= cpu_wd;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue-based reference model.
// Expectations follow STORE_FWD_EN when it is defined for the build.
module tb_store_buffer;
  import store_buffer_pkg::*;

`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wd;
  logic        cpu_stall;
  logic        ld_req;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        mem_WE;
  logic [9:0]  mem_Address;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;
  logic        empty;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  logic [31:0] mem     [256];
  logic [31:0] exp_mem [256];
  sb_entry_t   q [$];

  store_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wd      (cpu_wd),
    .cpu_stall   (cpu_stall),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_stall    (ld_stall),
    .mem_WE      (mem_WE),
    .mem_Address (mem_Address),
    .mem_WD      (mem_WD),
    .mem_RD      (mem_RD),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  assign mem_RD = mem[mem_Address[9:2]];

  always @(posedge clk)
    if (mem_WE) mem[mem_Address[9:2]] <= mem_WD;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(posedge rst) q.delete();

  // Reference model: FIFO of pending stores plus an expected memory image.
  logic        m_hit, m_ldport, m_drain, m_accept, m_ldstall;
  logic [31:0] m_fwd;
  sb_entry_t   m_e;

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      m_hit = 1'b0;
      m_fwd = '0;
      foreach (q[i])
        if (q[i].waddr == ld_addr[9:2]) begin
          m_hit = 1'b1;
          m_fwd = q[i].data;
        end
      m_ldport  = ld_req && !m_hit;
      m_drain   = !m_ldport && (q.size() != 0);
      m_accept  = cpu_we && ((q.size() < SB_DEPTH) || m_drain);
      m_ldstall = !FWD && ld_req && m_hit;

      check("mem_WE", 32'(mem_WE), 32'(m_drain));
      if (m_ldport)
        check("mem_Address_ld", 32'(mem_Address),
              32'({ld_addr[9:2], 2'b00}));
      if (m_drain) begin
        check("mem_Address_drain", 32'(mem_Address),
              32'({q[0].waddr, 2'b00}));
        check("mem_WD", mem_WD, q[0].data);
      end
      check("cpu_stall", 32'(cpu_stall), 32'(cpu_we && !m_accept));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("ld_stall", 32'(ld_stall), 32'(m_ldstall));
      if (ld_req && !m_ldstall)
        check("ld_data", ld_data,
              (FWD && m_hit) ? m_fwd : exp_mem[ld_addr[9:2]]);

      if (m_drain) begin
        exp_mem[q[0].waddr] = q[0].data;
        void'(q.pop_front());
      end
      if (m_accept) begin
        m_e.waddr = cpu_addr[9:2];
        m_e.data  = cpu_wd;
        q.push_back(m_e);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      exp_mem[i] = '0;
    end
    rst      = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = '0;
    cpu_wd   = '0;
    ld_req   = 1'b0;
    ld_addr  = '0;
    repeat (2) @(posedge clk);
    #1;
    ld_req = 1'b1;
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_mem_WE", 32'(mem_WE), 32'd0);
    check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    check("rst_ld_stall", 32'(ld_stall), 32'd0);
    ld_req = 1'b0;
    rst    = 1'b0;
    chk_en = 1'b1;
    cyc();

    // Single store drains on the next cycle.
    cpu_we = 1'b1; cpu_addr = 10'h010; cpu_wd = 32'hDEAD_BEEF;
    #1;
    check("s1_cpu_stall", 32'(cpu_stall), 32'd0);
    cyc();
    cpu_we = 1'b0;
    #1;
    check("s1_mem_WE", 32'(mem_WE), 32'd1);
    check("s1_mem_Address", 32'(mem_Address), 32'h010);
    check("s1_mem_WD", mem_WD, 32'hDEAD_BEEF);
    cyc();
    check("s1_empty", 32'(empty), 32'd1);
    check("s1_mem", mem[4], 32'hDEAD_BEEF);

    // Fill while loads hold the port; fifth store must stall.
    ld_req = 1'b1; ld_addr = 10'h200;
    for (int i = 0; i < 5; i++) begin
      cpu_we = 1'b1; cpu_addr = 10'(4 * i); cpu_wd = 32'h100 + i;
      #1;
      check("fill_cpu_stall", 32'(cpu_stall), (i == 4) ? 32'd1 : 32'd0);
      cyc();
    end
    cpu_we = 1'b0; ld_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_mem_WE", 32'(mem_WE), 32'd1);
      check("drain_mem_Address", 32'(mem_Address), 32'(4 * k));
      cyc();
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Full buffer: pop and accept together.
    ld_req = 1'b1; ld_addr = 10'h200;
    for (int i = 0; i < 4; i++) begin
      cpu_we = 1'b1; cpu_addr = 10'h040 + 10'(4 * i); cpu_wd = 32'h200 + i;
      cyc();
    end
    cpu_addr = 10'h050; cpu_wd = 32'h204; ld_req = 1'b0;
    #1;
    check("full_cpu_stall", 32'(cpu_stall), 32'd0);
    check("full_mem_Address", 32'(mem_Address), 32'h040);
    cyc();
    ld_req = 1'b1; cpu_addr = 10'h054; cpu_wd = 32'h205;
    #1;
    check("still_full_stall", 32'(cpu_stall), 32'd1);
    cpu_we = 1'b0; ld_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("full_drain_addr", 32'(mem_Address), 32'h044 + 32'(4 * k));
      cyc();
    end
    check("full_empty", 32'(empty), 32'd1);

    // Two stores to one word, then a load hitting it.
    ld_req = 1'b1; ld_addr = 10'h200;
    cpu_we = 1'b1; cpu_addr = 10'h020; cpu_wd = 32'd1;
    cyc();
    cpu_wd = 32'd2;
    cyc();
    cpu_we = 1'b0; ld_addr = 10'h022;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("hit_ld_stall", 32'(ld_stall), (c < 2 && !FWD) ? 32'd1 : 32'd0);
      if (c < 2) check("hit_mem_WD", mem_WD, 32'(c + 1));
      if (!ld_stall) check("hit_ld_data", ld_data, 32'd2);
      cyc();
    end
    check("hit_empty", 32'(empty), 32'd1);

    // Mid-cycle reset discards pending stores.
    ld_addr = 10'h200;
    for (int i = 0; i < 3; i++) begin
      cpu_we = 1'b1; cpu_addr = 10'h300 + 10'(4 * i); cpu_wd = 32'hA + i;
      cyc();
    end
    cpu_we = 1'b0;
    check("pre_rst_empty", 32'(empty), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_mem_WE", 32'(mem_WE), 32'd0);
    #1 rst = 1'b0;
    cyc();
    ld_req = 1'b0;
    repeat (5) cyc();
    for (int i = 0; i < 3; i++)
      check("rst_mem_untouched", mem[8'hC0 + i], 32'd0);

    for (int i = 0; i < 256; i++)
      check("final_mem", mem[i], exp_mem[i]);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
